multi_clk_divider: RTL
======================

# multi_clk_divider

Parametrised multi-channel successor to the single-output divider. Each of CHANNELS independent dividers derives a slow clock-enable-style square wave from `inclk`. Divisor changes are double-buffered and take effect only at a counter wrap, so outputs never glitch. Drives LED blink rates, tone generators and slow strobes from one shared board clock.

## Interface
- `CHANNELS`, default 4, number of independent divider channels (1..16)
- `WIDTH`, default 32, divisor/counter width in bits (2..32)
- `inclk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `enable`  in  CHANNELS  per-channel run; low freezes that channel
- `divisor`  in  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- `load`  in  CHANNELS  per-channel capture strobe for `divisor` (and duty fields)
- `outclk`  out  CHANNELS  divided output per channel, registered
- `tick`  out  CHANNELS  one-cycle pulse in first cycle of each output period
- `pending`  out  CHANNELS  shadow value captured, not yet active
- (MCD_DUTY_EN only) `high_count`  in  CHANNELS*WIDTH  high-phase length, same slicing
- (MCD_DUTY_EN only) `duty_sel`  in  CHANNELS  1 = duty mode, 0 = toggle mode

## Operation
- Per channel: active divisor D, counter cnt (0..D-1), shadow divisor S, pending flag; with MCD_DUTY_EN also active/shadow H and mode.
- Reset values: D=0, S=0, cnt=0, outclk=0, tick=0, pending=0.
- D=0: channel stopped; cnt held 0, outclk held 0, tick 0.
- Counting (enable=1, D≠0): if cnt==D-1 then cnt←0 (wrap) else cnt←cnt+1. D=1 wraps every cycle.
- Toggle mode: outclk inverts on every wrap → period 2·D cycles, 50% duty.
- Duty mode: outclk == (cnt < H) every cycle; period D; H=0 → constant 0; H≥D → constant 1.
- tick: toggle mode, high in the cycle outclk first reads 1 after a 0→1 transition; duty mode, high in every cycle where cnt==0 following a wrap or apply.
- enable=0: cnt, outclk, D held; tick forced 0; load still captures into shadow.
- load[i]=1: S←divisor slice (and H, mode), pending←1. Load while pending: overwrite, last wins.
- Apply: at a wrap with pending=1, D←S, cnt←0, pending←0; toggle mode outclk←0; duty mode outclk←(0<H_new).
- Apply when stopped (D=0) or enable=0: applied on the edge after the load edge; pending high for exactly one cycle.
- load on the same edge as a wrap: the wrap uses old D; new value waits for the next wrap.
- Loading divisor 0 while running: channel stops at next wrap, outclk 0.

## Timing
- All outputs registered; no combinational path input→output.
- load→pending: 1 cycle. Stopped channel: load edge k, D active from edge k+1, cnt=0 in cycle k+1.
- Toggle mode from apply: first outclk rise after D cycles, tick coincident with that first high cycle.
- reset mid-operation: all outputs 0 asynchronously; no pending value survives.

## Configuration
- `MCD_DUTY_EN` defined: `high_count`/`duty_sel` ports exist; per-channel duty mode as above.
- Not defined: ports absent, toggle mode only, no H storage; behaviour identical to duty_sel=0.

## Test plan
- Reset, load ch0 divisor 3, enable=1 -> outclk[0] period 6 (3 high/3 low), tick[0] once per 6 cycles; other channels stay 0.
- Ch1 running divisor 4, load 2 mid-period -> pending[1]=1 until next wrap; following half-periods 2 cycles, no runt pulse.
- Ch2 divisor 1 -> outclk[2] toggles every cycle (inclk/2); tick every second cycle.
- enable[0] low for 5 cycles mid-count -> cnt/outclk frozen, tick 0; resumes with remaining count unchanged.
- MCD_DUTY_EN: duty_sel=1, divisor 5, high_count 2 -> pattern 1,1,0,0,0 repeating; high_count 0 -> constant 0; high_count 7 -> constant 1, tick every 5 cycles.
- Assert reset mid-period with pending set -> outclk, tick, pending 0 at once; after release channel stopped until new load.

Source files
------------

// File: rtl/multi_clk_divider.sv
// ---------------------------------------------------------------------------
// multi_clk_divider
//
// Purpose: CHANNELS independent programmable dividers running off one shared
// clock. Each channel produces a registered square wave (outclk), a one-cycle
// period-start strobe (tick) and a flag showing that a newly loaded divisor
// is waiting to take effect (pending). New settings are double-buffered in
// a shadow register and only become active at a counter wrap, or on the
// next edge when the channel is stopped or disabled, so outputs never glitch.
//
// Optional feature macro: MCD_DUTY_EN
//   defined     -> high_count / duty_sel ports exist; each channel can run in
//                  duty mode (outclk = cnt < H, period D) or toggle mode.
//   not defined -> toggle mode only (period 2*D, 50% duty), no H storage.
//
// Ports:
//   inclk       in   system clock, all state changes on the rising edge
//   reset       in   asynchronous active-high reset, clears all state
//   enable      in   [CHANNELS] per-channel run; low freezes the channel
//   divisor     in   [CHANNELS*WIDTH] channel i at [i*WIDTH +: WIDTH]
//   load        in   [CHANNELS] capture divisor (and duty fields) to shadow
//   outclk      out  [CHANNELS] divided output, registered
//   tick        out  [CHANNELS] one-cycle pulse at the start of each period
//   pending     out  [CHANNELS] shadow value captured, not yet active
//   high_count  in   [CHANNELS*WIDTH] high-phase length (MCD_DUTY_EN only)
//   duty_sel    in   [CHANNELS] 1 = duty mode, 0 = toggle (MCD_DUTY_EN only)
// ---------------------------------------------------------------------------
module multi_clk_divider #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
) (
  input  logic                      inclk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS*WIDTH-1:0] divisor,
  input  logic [CHANNELS-1:0]       load,
  output logic [CHANNELS-1:0]       outclk,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       pending
`ifdef MCD_DUTY_EN
  ,
  input  logic [CHANNELS*WIDTH-1:0] high_count,
  input  logic [CHANNELS-1:0]       duty_sel
`endif
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] div_in_s;
    logic [WIDTH-1:0] act_div_r;
    logic [WIDTH-1:0] shd_div_r;
    logic [WIDTH-1:0] cnt_r;
    logic             out_r;
    logic             tick_r;
    logic             pend_r;

    logic             run_s;
    logic             wrap_s;
    logic             apply_s;
    logic [WIDTH-1:0] act_div_nx_s;
    logic [WIDTH-1:0] cnt_nx_s;
    logic             out_nx_s;
    logic             tick_nx_s;
    logic             pend_nx_s;

    // Active/shadow duty settings; tied off when the duty feature is absent
    logic             mode_s;
    logic             shd_mode_s;
    logic [WIDTH-1:0] act_high_s;
    logic [WIDTH-1:0] shd_high_s;

    assign div_in_s = divisor[i*WIDTH +: WIDTH];

`ifdef MCD_DUTY_EN
    logic [WIDTH-1:0] act_high_r;
    logic [WIDTH-1:0] shd_high_r;
    logic             act_mode_r;
    logic             shd_mode_r;

    assign mode_s     = act_mode_r;
    assign shd_mode_s = shd_mode_r;
    assign act_high_s = act_high_r;
    assign shd_high_s = shd_high_r;

    // Duty settings: shadow captures on load, active copies at apply
    always_ff @(posedge inclk or posedge reset) begin
      if (reset) begin
        act_high_r <= {WIDTH{1'b0}};
        shd_high_r <= {WIDTH{1'b0}};
        act_mode_r <= 1'b0;
        shd_mode_r <= 1'b0;
      end else begin
        if (apply_s) begin
          act_high_r <= shd_high_r;
          act_mode_r <= shd_mode_r;
        end
        if (load[i]) begin
          shd_high_r <= high_count[i*WIDTH +: WIDTH];
          shd_mode_r <= duty_sel[i];
        end
      end
    end
`else
    assign mode_s     = 1'b0;
    assign shd_mode_s = 1'b0;
    assign act_high_s = {WIDTH{1'b0}};
    assign shd_high_s = {WIDTH{1'b0}};
`endif

    // Next-state logic for counter, output, tick and pending flag
    always_comb begin
      run_s   = enable[i] && (act_div_r != {WIDTH{1'b0}});
      wrap_s  = run_s && (cnt_r == (act_div_r - WIDTH'(1'b1)));
      // A stopped or disabled channel has no wrap to wait for, so the
      // shadow value is applied on the very next edge.
      apply_s = pend_r && (wrap_s || (act_div_r == {WIDTH{1'b0}}) || !enable[i]);

      act_div_nx_s = act_div_r;
      cnt_nx_s     = cnt_r;
      out_nx_s     = out_r;
      tick_nx_s    = 1'b0;

      if (apply_s) begin
        act_div_nx_s = shd_div_r;
        cnt_nx_s     = {WIDTH{1'b0}};
        if (shd_div_r == {WIDTH{1'b0}}) begin
          out_nx_s = 1'b0;
        end else if (shd_mode_s) begin
          out_nx_s = (shd_high_s != {WIDTH{1'b0}});
        end else begin
          out_nx_s = 1'b0;
        end
        // Duty mode starts a fresh period at cnt==0; toggle mode starts low
        tick_nx_s = enable[i] && shd_mode_s && (shd_div_r != {WIDTH{1'b0}});
      end else if (run_s) begin
        if (wrap_s) begin
          cnt_nx_s = {WIDTH{1'b0}};
        end else begin
          cnt_nx_s = cnt_r + WIDTH'(1'b1);
        end
        if (mode_s) begin
          out_nx_s  = (cnt_nx_s < act_high_s);
          tick_nx_s = wrap_s;
        end else begin
          if (wrap_s) begin
            out_nx_s = !out_r;
          end else begin
            out_nx_s = out_r;
          end
          // Tick marks the first high cycle of each toggle period
          tick_nx_s = wrap_s && !out_r;
        end
      end else begin
        act_div_nx_s = act_div_r;
        cnt_nx_s     = cnt_r;
        out_nx_s     = out_r;
        tick_nx_s    = 1'b0;
      end

      if (load[i]) begin
        pend_nx_s = 1'b1;
      end else if (apply_s) begin
        pend_nx_s = 1'b0;
      end else begin
        pend_nx_s = pend_r;
      end
    end

    // Channel state registers
    always_ff @(posedge inclk or posedge reset) begin
      if (reset) begin
        act_div_r <= {WIDTH{1'b0}};
        shd_div_r <= {WIDTH{1'b0}};
        cnt_r     <= {WIDTH{1'b0}};
        out_r     <= 1'b0;
        tick_r    <= 1'b0;
        pend_r    <= 1'b0;
      end else begin
        act_div_r <= act_div_nx_s;
        cnt_r     <= cnt_nx_s;
        out_r     <= out_nx_s;
        tick_r    <= tick_nx_s;
        pend_r    <= pend_nx_s;
        if (load[i]) begin
          shd_div_r <= div_in_s;
        end
      end
    end

    assign outclk[i]  = out_r;
    assign tick[i]    = tick_r;
    assign pending[i] = pend_r;
  end

endmodule
